// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    // Direction encoding on up_dn
    localparam bit DIR_UP = 1'b1;
    localparam bit DIR_DN = 1'b0;

    // Limit behaviour encoding on SATURATE
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Clamp a value to the top of the count range. Operates on 32 bits so it
    // serves any legal WIDTH; callers truncate the result back to WIDTH.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] val,
                                                 input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count calculation: the step (or hold) value and a flag
// marking a boundary event (stepping up at MAX_VAL or down at zero).
module cnt_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic             i_up_dn,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_nxt_val,
    output logic             o_bnd_evt
);

    logic w_at_max;
    logic w_at_zero;

    // Explicit limit compares so a non-power-of-two modulus wraps correctly.
    assign w_at_max  = (i_cur == MAX_VAL);
    assign w_at_zero = (i_cur == '0);

    // Step selection: hold when disabled, otherwise step or handle the limit.
    always_comb begin
        o_nxt_val = i_cur;
        o_bnd_evt = 1'b0;
        if (i_en) begin
            case (i_up_dn)
                DIR_UP: begin
                    if (w_at_max) begin
                        o_bnd_evt = 1'b1;
                        o_nxt_val = (SATURATE == MODE_WRAP) ? '0 : MAX_VAL;
                    end else begin
                        o_nxt_val = i_cur + WIDTH'(1);
                    end
                end
                DIR_DN: begin
                    if (w_at_zero) begin
                        o_bnd_evt = 1'b1;
                        o_nxt_val = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
                    end else begin
                        o_nxt_val = i_cur - WIDTH'(1);
                    end
                end
                default: begin
                    o_nxt_val = i_cur;
                    o_bnd_evt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with parallel load, clear, wrap or
// saturate limits, a registered terminal-count pulse and a sticky boundary flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             bnd_flag
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_bnd_flag;

    logic [WIDTH-1:0] w_nxt_val;
    logic             w_bnd_evt;
    logic [WIDTH-1:0] w_load_clamped;

    // A load value above the count range lands on MAX_VAL.
    assign w_load_clamped = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_VAL)));

    cnt_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .i_cur     (r_out),
        .i_up_dn   (up_dn),
        .i_en      (en),
        .o_nxt_val (w_nxt_val),
        .o_bnd_evt (w_bnd_evt)
    );

    // State update with priority reset > clear > load > enable > hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out      <= '0;
            r_tc       <= 1'b0;
            r_bnd_flag <= 1'b0;
        end else if (clear) begin
            r_out      <= '0;
            r_tc       <= 1'b0;
            r_bnd_flag <= 1'b0;
        end else if (load) begin
            r_out <= w_load_clamped;
            r_tc  <= 1'b0;
        end else if (en) begin
            r_out <= w_nxt_val;
            r_tc  <= w_bnd_evt;
            if (w_bnd_evt) begin
                r_bnd_flag <= 1'b1;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign out      = r_out;
    assign tc       = r_tc;
    assign bnd_flag = r_bnd_flag;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a wrapping modulo-10 instance and
// a saturating 4-bit instance share one set of stimulus inputs.
module tb_param_updown_counter;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       clear;

    logic [3:0] w_out;
    logic       w_tc;
    logic       w_bnd;
    logic [3:0] s_out;
    logic       s_tc;
    logic       s_bnd;

    int n_checks;
    int n_pass;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear),
        .out(w_out), .tc(w_tc), .bnd_flag(w_bnd)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear),
        .out(s_out), .tc(s_tc), .bnd_flag(s_bnd)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin : stim
        int t2_out[11];
        int t3_out[5];
        int t3_tc[5];
        n_checks = 0;
        n_pass   = 0;
        rstn = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clear = 1'b0;

        // 1. Reset, then wrap-count up through 9
        tick(); tick();
        check("rst_w_out", 32'(w_out), 0);
        check("rst_w_tc",  32'(w_tc),  0);
        check("rst_w_bnd", 32'(w_bnd), 0);
        check("rst_s_out", 32'(s_out), 0);
        rstn = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("up_w_out_%0d", k), 32'(w_out), 32'(k % 10));
            check($sformatf("up_w_tc_%0d", k),  32'(w_tc),  (k == 10) ? 1 : 0);
            check($sformatf("up_w_bnd_%0d", k), 32'(w_bnd), (k >= 10) ? 1 : 0);
            check($sformatf("up_s_out_%0d", k), 32'(s_out), 32'(k));
        end

        // 2. Load above range clamps; en ignored; then count down through 0
        load = 1'b1; load_val = 4'd14;
        tick();
        check("ld_w_out", 32'(w_out), 9);
        check("ld_w_tc",  32'(w_tc),  0);
        check("ld_w_bnd", 32'(w_bnd), 1);
        check("ld_s_out", 32'(s_out), 14);
        load = 1'b0; up_dn = 1'b0;
        t2_out = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("dn_w_out_%0d", k), 32'(w_out), 32'(t2_out[k]));
            check($sformatf("dn_w_tc_%0d", k),  32'(w_tc),  (k == 9) ? 1 : 0);
        end
        check("dn_s_out", 32'(s_out), 3);
        check("dn_s_bnd", 32'(s_bnd), 0);

        // 3. Saturate at the top, then step back down
        load = 1'b1; load_val = 4'd13;
        tick();
        check("ld13_s_out", 32'(s_out), 13);
        load = 1'b0; up_dn = 1'b1;
        t3_out = '{14, 15, 15, 15, 15};
        t3_tc  = '{0, 0, 1, 1, 1};
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat_s_out_%0d", k), 32'(s_out), 32'(t3_out[k]));
            check($sformatf("sat_s_tc_%0d", k),  32'(s_tc),  32'(t3_tc[k]));
        end
        check("sat_s_bnd", 32'(s_bnd), 1);
        up_dn = 1'b0;
        tick();
        check("sat_dn_s_out", 32'(s_out), 14);
        check("sat_dn_s_tc",  32'(s_tc),  0);
        // Saturate at zero, then disable: tc drops, count holds
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0;
        tick();
        check("sat0_s_out", 32'(s_out), 0);
        check("sat0_s_tc",  32'(s_tc),  0);
        tick();
        check("sat0h_s_out", 32'(s_out), 0);
        check("sat0h_s_tc",  32'(s_tc),  1);
        en = 1'b0;
        tick();
        check("off_s_out", 32'(s_out), 0);
        check("off_s_tc",  32'(s_tc),  0);

        // 4. Priority: clear beats load and en; load beats en
        load = 1'b1; load_val = 4'd5;
        tick();
        check("pr_w_out5", 32'(w_out), 5);
        check("pr_w_bnd1", 32'(w_bnd), 1);
        clear = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; up_dn = 1'b1;
        tick();
        check("clr_w_out", 32'(w_out), 0);
        check("clr_w_bnd", 32'(w_bnd), 0);
        check("clr_s_bnd", 32'(s_bnd), 0);
        check("clr_w_tc",  32'(w_tc),  0);
        clear = 1'b0;
        tick();
        check("ldpri_w_out", 32'(w_out), 7);

        // 5. Reset mid-count overrides load and en
        load_val = 4'd9;
        tick();
        load = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre_rst_w_out", 32'(w_out), 6);
        check("pre_rst_w_bnd", 32'(w_bnd), 1);
        rstn = 1'b0; load = 1'b1; load_val = 4'd3;
        tick();
        check("mid_rst_w_out", 32'(w_out), 0);
        check("mid_rst_w_tc",  32'(w_tc),  0);
        check("mid_rst_w_bnd", 32'(w_bnd), 0);
        rstn = 1'b1; load = 1'b0;
        tick();
        check("resume_w_out1", 32'(w_out), 1);
        tick();
        check("resume_w_out2", 32'(w_out), 2);

        // 6. Enable off holds; direction flips apply on the same edge
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_w_out_%0d", k), 32'(w_out), 3);
            check($sformatf("hold_w_tc_%0d", k),  32'(w_tc),  0);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_dn = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("flip_w_out_%0d", k), 32'(w_out), (k % 2 == 0) ? 4 : 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
